// File: rtl/game_ctrl.sv
// game_ctrl: frame-paced Pong match sequencer driving paddle/ball enables, scores and winner
module game_ctrl #(
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       vblnk,
  input  logic       btn_start,
  input  logic       miss_left,
  input  logic       miss_right,
  output logic       paddle_en,
  output logic       ball_en,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic [1:0] winner,
  output logic [2:0] state
);
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    PAUSE = 3'd3,
    POINT = 3'd4,
    OVER  = 3'd5
  } state_t;
  localparam logic [7:0] SF8  = 8'(SERVE_FRAMES);
  localparam logic [7:0] PF8  = 8'(POINT_FRAMES);
  localparam logic [3:0] WIN4 = 4'(WIN_SCORE);
  state_t st, st_n;
  logic [7:0] cnt, cnt_n;
  logic [3:0] sl_n, sr_n;
  logic [1:0] win_n;
  logic dir_n, btn_s1, btn_s2, btn_s3, start_edge, vblnk_d, frame_tick, expire;
  always_ff @(posedge clk or posedge rst)
    if (rst) {btn_s1, btn_s2, btn_s3, start_edge, vblnk_d, frame_tick} <= '0;
    else begin
      btn_s1     <= btn_start;
      btn_s2     <= btn_s1;
      btn_s3     <= btn_s2;
      start_edge <= btn_s2 & ~btn_s3;
      vblnk_d    <= vblnk;
      frame_tick <= vblnk & ~vblnk_d;
    end
  assign expire = frame_tick && cnt == 8'd1;
  // SERVE and POINT only watch the frame counter, so a start press there is dropped
  always_comb begin
    st_n  = st;
    cnt_n = cnt;
    sl_n  = score_l;
    sr_n  = score_r;
    win_n = winner;
    dir_n = serve_dir;
    case (st)
      IDLE:
        if (start_edge) begin
          st_n  = SERVE;
          cnt_n = SF8;
          sl_n  = '0;
          sr_n  = '0;
          win_n = '0;
          dir_n = 1'b1;
        end
      SERVE:
        if (expire) st_n = PLAY;
        else if (frame_tick) cnt_n = cnt - 8'd1;
      PLAY:
        if (miss_left && miss_right) begin
          st_n  = SERVE;
          cnt_n = SF8;
        end else if (miss_left || miss_right) begin
          sr_n  = score_r + {3'd0, miss_left};
          sl_n  = score_l + {3'd0, miss_right};
          dir_n = miss_right;
          if (sl_n == WIN4 || sr_n == WIN4) begin
            st_n  = OVER;
            win_n = {miss_left, miss_right};
          end else begin
            st_n  = POINT;
            cnt_n = PF8;
          end
        end else if (start_edge) st_n = PAUSE;
      PAUSE:
        if (start_edge) st_n = PLAY;
      POINT:
        if (expire) begin
          st_n  = SERVE;
          cnt_n = SF8;
        end else if (frame_tick) cnt_n = cnt - 8'd1;
      OVER:
        if (start_edge) st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end
  // enables are decoded from the next state so they change on the same edge as state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st         <= IDLE;
      cnt        <= '0;
      score_l    <= '0;
      score_r    <= '0;
      winner     <= '0;
      serve_dir  <= 1'b1;
      paddle_en  <= 1'b0;
      ball_en    <= 1'b0;
      ball_reset <= 1'b1;
    end else begin
      st         <= st_n;
      cnt        <= cnt_n;
      score_l    <= sl_n;
      score_r    <= sr_n;
      winner     <= win_n;
      serve_dir  <= dir_n;
      paddle_en  <= st_n inside {SERVE, PLAY, POINT};
      ball_en    <= st_n == PLAY;
      ball_reset <= st_n inside {IDLE, SERVE, OVER};
    end
  assign state = st;
endmodule

// File: doc/game_ctrl.md
# game_ctrl

Pong match sequencer: a frame-paced finite state machine that controls the paddle-drawing and ball stages over a match. It gates paddle movement, arms and launches the ball, keeps both scores, and declares a winner. It sits beside the VGA pipeline. It samples the timing signal `vblnk` for frame pacing, takes miss events from the ball logic, and drives enable and reset strobes back into the draw stages.

## Interface
Parameters:
- `WIN_SCORE`, default 5: points needed to win. Legal range is 1..15.
- `SERVE_FRAMES`, default 60: frames spent in SERVE before launch. Legal range is 1..255.
- `POINT_FRAMES`, default 90: frames spent in POINT after a score. Legal range is 1..255.

Ports:
- `clk`, in, 1: pixel clock. There is only one clock.
- `rst`, in, 1: reset, asynchronous and active-high.
- `vblnk`, in, 1: vertical blank from the timing stage.
- `btn_start`, in, 1: start/pause button. It is raw and asynchronous to `clk`.
- `miss_left`, in, 1: one-cycle pulse; the ball passed the left paddle.
- `miss_right`, in, 1: one-cycle pulse; the ball passed the right paddle.
- `paddle_en`, out, 1: paddle movement allowed.
- `ball_en`, out, 1: ball motion allowed.
- `ball_reset`, out, 1: hold the ball at screen centre.
- `serve_dir`, out, 1: launch direction. 1 means rightwards, 0 means leftwards.
- `score_l`, out, 4: left player score.
- `score_r`, out, 4: right player score.
- `winner`, out, 2: match result. 00 means none, 01 means left, 10 means right.
- `state`, out, 3: current state code, for the HUD and debug.

## Operation
Input conditioning:
- `btn_start` passes through a 2-FF synchroniser.
- `start_edge` is the rising edge of the synchronised signal, one cycle wide.
- `frame_tick` is the rising edge of `vblnk`, one cycle wide.

Frame counter:
- 8-bit down-counter, loaded on each state entry that needs a delay.
- Decrements on `frame_tick`.
- The state exits when the counter is 1 and `frame_tick` is asserted.

States and transitions:
- IDLE (code 0): `paddle_en`=0, `ball_en`=0, `ball_reset`=1. On `start_edge`: clear both scores, set `winner`=00, set `serve_dir`=1, load `SERVE_FRAMES`, go to SERVE.
- SERVE (code 1): `paddle_en`=1, `ball_en`=0, `ball_reset`=1. When the counter expires, go to PLAY.
- PLAY (code 2): `paddle_en`=1, `ball_en`=1, `ball_reset`=0. Event priority, highest first:
  1. Both `miss_left` and `miss_right` in the same cycle: no score change, load `SERVE_FRAMES`, go to SERVE.
  2. `miss_left`: increment `score_r`, set `serve_dir`=0.
  3. `miss_right`: increment `score_l`, set `serve_dir`=1.
  4. `start_edge` with no miss: go to PAUSE.
- After a single miss, compare the *incremented* score to `WIN_SCORE`. If equal, set `winner` and go to OVER. Otherwise load `POINT_FRAMES` and go to POINT.
- PAUSE (code 3): all enables are 0 and `ball_reset`=0, so the ball freezes in place. On `start_edge`, return to PLAY.
- POINT (code 4): `paddle_en`=1, `ball_en`=0, `ball_reset`=0. When the counter expires, load `SERVE_FRAMES` and go to SERVE.
- OVER (code 5): `paddle_en`=0, `ball_en`=0, `ball_reset`=1. Scores and `winner` are held. On `start_edge`, go to IDLE.
- Codes 6 and 7 are illegal. They go to IDLE on the next clock.

Miss handling outside PLAY:
- Miss pulses are ignored in every state other than PLAY.

Score arithmetic:
- Scores are 4 bits and unsigned.
- A score cannot exceed `WIN_SCORE`, so the counters never wrap.

## Timing
- Every output is registered. Enables follow `state` on the same edge, so their latency is 0 cycles relative to `state`.
- `btn_start` to `start_edge`: 3 clock edges (2 synchroniser stages plus the edge register). A state change happens one edge after that.
- `vblnk` rising to `frame_tick`: 1 cycle.
- Miss pulse to score update and state change: one clock edge, both on the same edge.
- SERVE lasts exactly `SERVE_FRAMES` `frame_tick` events. POINT lasts exactly `POINT_FRAMES` `frame_tick` events.
- Reset values, applied immediately when `rst` asserts, including mid-match:
  - `state`=IDLE.
  - `paddle_en`=0, `ball_en`=0, `ball_reset`=1.
  - `serve_dir`=1, scores 0, `winner`=00.
  - Counter 0, synchroniser and edge registers 0.
- A `start_edge` that coincides with a counter expiry in SERVE or POINT is ignored. The expiry wins.

## Test plan
1. Assert `rst` and release it, then pulse `btn_start` → 4 cycles later `state`=1, `ball_reset`=1, `paddle_en`=1. After 60 `vblnk` rises, `state`=2 and `ball_en`=1.
2. In PLAY, pulse `miss_right` → next cycle `score_l`=1, `serve_dir`=1, `state`=4. After 90 frames, `state`=1.
3. With `score_r`=4, pulse `miss_left` → `score_r`=5, `winner`=10, `state`=5, all enables 0. Then press `btn_start` → `state`=0. Press `btn_start` again → scores return to 0.
4. Pulse `miss_left` and `miss_right` in the same cycle during PLAY → scores unchanged, `state`=1.
5. Press `btn_start` in PLAY → `state`=3, `ball_en`=0, `paddle_en`=0. Press again → `state`=2. A miss pulse applied during PAUSE changes no score.
6. Assert `rst` mid-POINT with scores 3:2 → all outputs take their reset values asynchronously, before the next clock edge.
